// File: rtl/palette_scanout.sv
// Scanout read master: fetches 2-pixel RGB565 words from the palette slave
// through a credit-limited FIFO and emits them as a framed pixel stream.
module palette_scanout #(
    parameter int unsigned H_PIXELS   = 480,
    parameter int unsigned V_LINES    = 272,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [23:0] frame_base,
    output logic        busy,
    output logic        frame_done,
    output logic        avm_read,
    output logic [23:0] avm_address,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eol
);

    localparam int unsigned WORDS  = H_PIXELS * V_LINES / 2;
    localparam int unsigned PIXELS = H_PIXELS * V_LINES;
    localparam int unsigned IW     = $clog2(WORDS + 1);
    localparam int unsigned PW     = $clog2(PIXELS + 1);
    localparam int unsigned CW     = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned XW     = $clog2(H_PIXELS);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] issue_q, issue_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          half_q, half_d;
    logic [PW-1:0] pix_cnt_q, pix_cnt_d;
    logic [XW-1:0] col_q, col_d;
    logic [31:0]   mem [FIFO_DEPTH];

    logic          busy_d, frame_done_d, avm_read_d;
    logic [23:0]   avm_address_d;
    logic [15:0]   pix_data_d;
    logic          pix_valid_d, pix_sof_d, pix_eol_d;
    logic [31:0]   head_word;

    logic rd_acc, push, pix_acc, pop, last_pix;

    // Handshake events of the current cycle
    always_comb begin
        rd_acc   = avm_read && !avm_waitrequest;
        push     = avm_readdatavalid && (state_q != IDLE);
        pix_acc  = pix_valid && pix_ready;
        pop      = pix_acc && half_q;
        last_pix = pix_acc && (pix_cnt_q == PW'(PIXELS - 1));
    end

    // Next-state, counters, read request and next pixel presentation
    always_comb begin
        state_d       = state_q;
        issue_d       = issue_q + IW'(rd_acc);
        avm_address_d = avm_address + 24'(rd_acc);
        outst_d       = outst_q + CW'(rd_acc) - CW'(push);
        count_d       = count_q + CW'(push) - CW'(pop);
        wr_ptr_d      = wr_ptr_q + AW'(push);
        rd_ptr_d      = rd_ptr_q + AW'(pop);
        half_d        = half_q ^ pix_acc;
        pix_cnt_d     = pix_cnt_q + PW'(pix_acc);
        col_d         = col_q;
        frame_done_d  = 1'b0;
        avm_read_d    = 1'b0;
        head_word     = 32'h0;

        if (pix_acc) begin
            col_d = (col_q == XW'(H_PIXELS - 1)) ? '0 : col_q + XW'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = FETCH;
                    issue_d       = '0;
                    pix_cnt_d     = '0;
                    col_d         = '0;
                    half_d        = 1'b0;
                    outst_d       = '0;
                    avm_address_d = frame_base;
                end
            end
            FETCH: begin
                if (issue_d == IW'(WORDS)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pix) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A stalled request is held; a new one needs a guaranteed FIFO slot
        if (avm_read && avm_waitrequest) begin
            avm_read_d = 1'b1;
        end else begin
            avm_read_d = (state_d == FETCH) &&
                         (32'(outst_d) + 32'(count_d) + 32'd1 <= FIFO_DEPTH);
        end

        busy_d = (state_d != IDLE);

        // Word arriving into an otherwise empty FIFO is forwarded directly
        if ((count_q - CW'(pop)) == '0) begin
            head_word = avm_readdata;
        end else begin
            head_word = mem[rd_ptr_d];
        end
        pix_valid_d = (count_d != '0);
        pix_data_d  = pix_valid_d ? (half_d ? head_word[15:0] : head_word[31:16]) : 16'h0;
        pix_sof_d   = pix_valid_d && (pix_cnt_d == '0);
        pix_eol_d   = pix_valid_d && (col_d == XW'(H_PIXELS - 1));
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            issue_q     <= '0;
            outst_q     <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            half_q      <= 1'b0;
            pix_cnt_q   <= '0;
            col_q       <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            avm_read    <= 1'b0;
            avm_address <= 24'h0;
            pix_data    <= 16'h0;
            pix_valid   <= 1'b0;
            pix_sof     <= 1'b0;
            pix_eol     <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_q     <= issue_d;
            outst_q     <= outst_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            half_q      <= half_d;
            pix_cnt_q   <= pix_cnt_d;
            col_q       <= col_d;
            busy        <= busy_d;
            frame_done  <= frame_done_d;
            avm_read    <= avm_read_d;
            avm_address <= avm_address_d;
            pix_data    <= pix_data_d;
            pix_valid   <= pix_valid_d;
            pix_sof     <= pix_sof_d;
            pix_eol     <= pix_eol_d;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= avm_readdata;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !pop && (count_q == CW'(FIFO_DEPTH))));

    a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && (outst_q == '0)));

endmodule
